// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing and frame-buffer read strobe generator.
// Ports: VGA_CLK pixel clock; VGA_RESET async active-high reset;
//   VGA_HS/VGA_VS active-low syncs; VGA_BLANK_N high in the active window;
//   READ_Request read strobe leading the active window by READ_LEAD clocks;
//   H_Cont/V_Cont raster position; Frame_Start one-clock pulse at (0,0);
//   Frame_Cnt frame counter, live only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int READ_LEAD = 1
) (
  input  logic        VGA_CLK,
  input  logic        VGA_RESET,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        READ_Request,
  output logic [10:0] H_Cont,
  output logic [10:0] V_Cont,
  output logic        Frame_Start,
  output logic [15:0] Frame_Cnt
);
  // 12-bit bounds so an end-of-window value of 2048 still compares correctly
  localparam logic [11:0] HT = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [11:0] HS = 12'(H_SYNC);
  localparam logic [11:0] HA = 12'(H_SYNC + H_BP);
  localparam logic [11:0] HE = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] RS = 12'(H_SYNC + H_BP - READ_LEAD);
  localparam logic [11:0] RE = 12'(H_SYNC + H_BP + H_ACTIVE - READ_LEAD);
  localparam logic [11:0] VT = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [11:0] VS = 12'(V_SYNC);
  localparam logic [11:0] VA = 12'(V_SYNC + V_BP);
  localparam logic [11:0] VE = 12'(V_SYNC + V_BP + V_ACTIVE);
  logic [11:0] h_n, v_n;
  logic h_end, v_end, v_act, fs_n;
  // decode from next-state counters so registered outputs line up with H_Cont/V_Cont
  always_comb begin
    h_end = {1'b0, H_Cont} == HT - 12'd1;
    v_end = {1'b0, V_Cont} == VT - 12'd1;
    h_n   = h_end ? 12'd0 : {1'b0, H_Cont} + 12'd1;
    v_n   = h_end ? (v_end ? 12'd0 : {1'b0, V_Cont} + 12'd1) : {1'b0, V_Cont};
    v_act = v_n >= VA && v_n < VE;
    fs_n  = h_n == 12'd0 && v_n == 12'd0;
  end
  always_ff @(posedge VGA_CLK or posedge VGA_RESET) begin
    if (VGA_RESET) begin
      H_Cont       <= '0;
      V_Cont       <= '0;
      VGA_HS       <= 1'b1;
      VGA_VS       <= 1'b1;
      VGA_BLANK_N  <= 1'b0;
      READ_Request <= 1'b0;
      Frame_Start  <= 1'b0;
    end else begin
      H_Cont       <= h_n[10:0];
      V_Cont       <= v_n[10:0];
      VGA_HS       <= h_n >= HS;
      VGA_VS       <= v_n >= VS;
      VGA_BLANK_N  <= v_act && h_n >= HA && h_n < HE;
      READ_Request <= v_act && h_n >= RS && h_n < RE;
      Frame_Start  <= fs_n;
    end
  end
`ifdef VGA_TIMING_FRAME_CNT_EN
  // advances on the same edge that raises Frame_Start
  always_ff @(posedge VGA_CLK or posedge VGA_RESET) begin
    if (VGA_RESET) Frame_Cnt <= '0;
    else Frame_Cnt <= Frame_Cnt + 16'(fs_n);
  end
`else
  assign Frame_Cnt = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen (small, lead-0 and default configs).
module tb_vga_timing_gen;
  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic hs, vs, bl, rr, fs;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic s_hs, s_vs, s_bl, s_rr, s_fs, z_hs, z_vs, z_bl, z_rr, z_fs, d_hs, d_vs, d_bl, d_rr, d_fs;
  logic [10:0] s_h, s_v, z_h, z_v, d_h, d_v;
  logic [15:0] s_fc, z_fc, d_fc;
  exp_t s_obs, z_obs, d_obs;
  assign s_obs = {s_h, s_v, s_hs, s_vs, s_bl, s_rr, s_fs, s_fc};
  assign z_obs = {z_h, z_v, z_hs, z_vs, z_bl, z_rr, z_fs, z_fc};
  assign d_obs = {d_h, d_v, d_hs, d_vs, d_bl, d_rr, d_fs, d_fc};

  vga_timing_gen #(.H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2), .V_SYNC(1), .V_BP(1),
    .V_ACTIVE(3), .V_FP(1), .READ_LEAD(1)) u_s (
    .VGA_CLK(clk), .VGA_RESET(rst), .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bl),
    .READ_Request(s_rr), .H_Cont(s_h), .V_Cont(s_v), .Frame_Start(s_fs), .Frame_Cnt(s_fc));
  vga_timing_gen #(.H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2), .V_SYNC(1), .V_BP(1),
    .V_ACTIVE(3), .V_FP(1), .READ_LEAD(0)) u_z (
    .VGA_CLK(clk), .VGA_RESET(rst), .VGA_HS(z_hs), .VGA_VS(z_vs), .VGA_BLANK_N(z_bl),
    .READ_Request(z_rr), .H_Cont(z_h), .V_Cont(z_v), .Frame_Start(z_fs), .Frame_Cnt(z_fc));
  vga_timing_gen u_d (
    .VGA_CLK(clk), .VGA_RESET(rst), .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_bl),
    .READ_Request(d_rr), .H_Cont(d_h), .V_Cont(d_v), .Frame_Start(d_fs), .Frame_Cnt(d_fc));

  int checks = 0;
  int errors = 0;
  int k = 0;
  int rr_line[6];
  int bl_line[6];
  int fs_cnt = 0, hs_l0 = 0, hs_l1 = 0, d_rr35 = 0, d_rr34 = 0, d_hs0 = 0;
  exp_t sq[$], zq[$], dq[$];

  // k = rising edges since reset release; position follows directly from k
  function automatic exp_t model(input int kk, hs_w, hb, ha, hf, vs_w, vb, va, vf, lead);
    exp_t e;
    int ht, vt, ft, p, h, v;
    logic vact;
    e = '0;
    if (kk == 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      return e;
    end
    ht = hs_w + hb + ha + hf;
    vt = vs_w + vb + va + vf;
    ft = ht * vt;
    p = kk % ft;
    h = p % ht;
    v = p / ht;
    vact = v >= vs_w + vb && v < vs_w + vb + va;
    e.h = 11'(h);
    e.v = 11'(v);
    e.hs = h >= hs_w;
    e.vs = v >= vs_w;
    e.bl = vact && h >= hs_w + hb && h < hs_w + hb + ha;
    e.rr = vact && h >= hs_w + hb - lead && h < hs_w + hb + ha - lead;
    e.fs = p == 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    e.fc = 16'(kk / ft);
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    sq.push_back(model(k + 1, 2, 2, 4, 2, 1, 1, 3, 1, 1));
    zq.push_back(model(k + 1, 2, 2, 4, 2, 1, 1, 3, 1, 0));
    dq.push_back(model(k + 1, 96, 48, 640, 16, 2, 33, 480, 10, 1));
    @(posedge clk);
    #1;
    k++;
    chk("small", s_obs, sq.pop_front());
    chk("lead0", z_obs, zq.pop_front());
    chk("dflt", d_obs, dq.pop_front());
    chk("lead0_rr_eq_blank", z_rr, z_bl);
    if (k >= 60 && k < 120 && s_v < 11'd6) begin
      rr_line[s_v] += int'(s_rr);
      bl_line[s_v] += int'(s_bl);
    end
    fs_cnt += int'(s_fs);
    if (k >= 1 && k < 10) hs_l0 += int'(!s_hs);
    if (k >= 10 && k < 20) hs_l1 += int'(!s_hs);
    if (k >= 1 && k < 800) d_hs0 += int'(!d_hs);
    if (k >= 27200 && k < 28000) d_rr34 += int'(d_rr);
    if (k >= 28000 && k < 28800) d_rr35 += int'(d_rr);
  endtask

  initial begin
    int tot;
    int fc_exp;
    for (int i = 0; i < 6; i++) begin
      rr_line[i] = 0;
      bl_line[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_small", s_obs, model(0, 2, 2, 4, 2, 1, 1, 3, 1, 1));
    chk("rst_lead0", z_obs, model(0, 2, 2, 4, 2, 1, 1, 3, 1, 0));
    chk("rst_dflt", d_obs, model(0, 96, 48, 640, 16, 2, 33, 480, 10, 1));
    rst = 1'b0;
    k = 0;
    repeat (300) step();
    tot = 0;
    for (int v = 0; v < 6; v++) begin
      chk($sformatf("rr_line%0d", v), rr_line[v], (v >= 2 && v <= 4) ? 4 : 0);
      chk($sformatf("bl_line%0d", v), bl_line[v], (v >= 2 && v <= 4) ? 4 : 0);
      tot += rr_line[v];
    end
    chk("rr_frame", tot, 12);
    chk("fs_cnt_5frames", fs_cnt, 5);
    chk("hs_low_first_line", hs_l0, 1);
    chk("hs_low_second_line", hs_l1, 2);
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc_exp = 5;
`else
    fc_exp = 0;
`endif
    chk("frame_cnt_5frames", s_fc, fc_exp);
    while (k % 60 != 35) step();
    chk("pre_rst_h", s_h, 5);
    chk("pre_rst_v", s_v, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_small", s_obs, model(0, 2, 2, 4, 2, 1, 1, 3, 1, 1));
    chk("async_rst_lead0", z_obs, model(0, 2, 2, 4, 2, 1, 1, 3, 1, 0));
    chk("async_rst_dflt", d_obs, model(0, 96, 48, 640, 16, 2, 33, 480, 10, 1));
    @(posedge clk);
    #1;
    chk("rst_held_small", s_obs, model(0, 2, 2, 4, 2, 1, 1, 3, 1, 1));
    rst = 1'b0;
    k = 0;
    d_hs0 = 0;
    d_rr34 = 0;
    d_rr35 = 0;
    step();
    chk("post_rst_h", s_h, 1);
    chk("post_rst_v", s_v, 0);
    repeat (28799) step();
    chk("dflt_hs_low_first_line", d_hs0, 95);
    chk("dflt_rr_line34", d_rr34, 0);
    chk("dflt_rr_line35", d_rr35, 640);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
